// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I opcodes, control FSM state codes and mux select encodings
package rv32i_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
endpackage

// File: rtl/opcode_class_decode.sv
// opcode_class_decode: classifies a 7-bit RV32I opcode into the properties the control FSM needs
module opcode_class_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_branch,
  output logic       o_is_jump,
  output logic       o_writes_rd,
  output logic       o_uses_pc_a,
  output logic       o_uses_imm_b
);
  logic w_op, w_opimm, w_jal, w_jalr, w_lui, w_auipc, w_fence, w_system;
  assign w_op     = i_opcode == OPC_OP;
  assign w_opimm  = i_opcode == OPC_OPIMM;
  assign w_jal    = i_opcode == OPC_JAL;
  assign w_jalr   = i_opcode == OPC_JALR;
  assign w_lui    = i_opcode == OPC_LUI;
  assign w_auipc  = i_opcode == OPC_AUIPC;
  assign w_fence  = i_opcode == OPC_FENCE;
  assign w_system = i_opcode == OPC_SYSTEM;
  assign o_is_load   = i_opcode == OPC_LOAD;
  assign o_is_store  = i_opcode == OPC_STORE;
  assign o_is_branch = i_opcode == OPC_BRANCH;
  assign o_is_jump   = w_jal | w_jalr;
  assign o_legal     = w_op | w_opimm | o_is_load | o_is_store | o_is_branch | o_is_jump
                     | w_lui | w_auipc | w_fence | w_system;
  assign o_writes_rd  = w_op | w_opimm | o_is_load | o_is_jump | w_lui | w_auipc;
  // Branch target and JAL/AUIPC results are PC-relative
  assign o_uses_pc_a  = w_auipc | w_jal | o_is_branch;
  assign o_uses_imm_b = w_opimm | o_is_load | o_is_store | o_is_branch | o_is_jump | w_lui | w_auipc;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM driving datapath enables, mux selects and memory handshake
module multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter bit HALT_ON_SYSTEM = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_insn,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             retire,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  logic [2:0]       r_state, w_next;
  logic [CNT_W-1:0] r_instret;
  logic w_legal, w_is_load, w_is_store, w_is_branch, w_is_jump, w_writes_rd, w_uses_pc_a, w_uses_imm_b;
  logic w_fetch, w_exec, w_mem, w_wb, w_alu_st, w_halt_dec, w_retire;
  logic [2:0] w_after_retire;
  opcode_class_decode u_dec (
    .i_opcode    (opcode),
    .o_legal     (w_legal),
    .o_is_load   (w_is_load),
    .o_is_store  (w_is_store),
    .o_is_branch (w_is_branch),
    .o_is_jump   (w_is_jump),
    .o_writes_rd (w_writes_rd),
    .o_uses_pc_a (w_uses_pc_a),
    .o_uses_imm_b(w_uses_imm_b)
  );
  assign w_fetch  = r_state == ST_FETCH;
  assign w_exec   = r_state == ST_EXEC;
  assign w_mem    = r_state == ST_MEM;
  assign w_wb     = r_state == ST_WB;
  // ALU operands stay selected through MEM/WB so the address and jump target remain stable
  assign w_alu_st = w_exec | w_mem | w_wb;
  assign w_halt_dec = !w_legal || (HALT_ON_SYSTEM && opcode == OPC_SYSTEM);
  // EXEC retires anything that neither touches memory nor writes rd: branch, FENCE, non-halting SYSTEM
  assign w_retire = (w_exec && !w_is_load && !w_is_store && !w_writes_rd)
                  | (w_mem && mem_ready && w_is_store) | w_wb;
  assign w_after_retire = run ? ST_FETCH : ST_IDLE;
  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: w_next = w_halt_dec ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_next = (w_is_load | w_is_store) ? ST_MEM : w_writes_rd ? ST_WB : w_after_retire;
      ST_MEM:    w_next = !mem_ready ? ST_MEM : w_is_load ? ST_WB : w_after_retire;
      ST_WB:     w_next = w_after_retire;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase
  end
  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end
  assign mem_req      = w_fetch | w_mem;
  assign mem_sel_insn = w_fetch;
  assign mem_we       = w_mem & w_is_store;
  assign ir_we        = w_fetch & mem_ready;
  assign pc_we        = w_retire;
  assign pc_sel       = (w_exec && w_is_branch && branch_taken) ? PC_BRANCH
                      : (w_wb && w_is_jump) ? PC_ALU : PC_PLUS4;
  assign reg_we       = w_wb;
  assign wb_sel       = !w_wb ? WB_ALU : w_is_load ? WB_MEM : w_is_jump ? WB_PC4 : WB_ALU;
  assign alu_a_sel    = w_alu_st & w_uses_pc_a;
  assign alu_b_sel    = w_alu_st & w_uses_imm_b;
  assign retire       = w_retire;
  assign halted       = r_state == ST_HALT;
  assign state        = r_state;
  assign instret      = r_instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for the multi-cycle control FSM
module tb_multicycle_ctrl;
  logic       clk = 1'b1;
  logic       reset, run, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, mem_sel_insn, ir_we, pc_we, reg_we, alu_a_sel, alu_b_sel, retire, halted;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;
  logic [3:0] instret;
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] fl;
    logic [1:0] pcs;
    logic [1:0] wbs;
    logic [1:0] ab;
    logic [3:0] inst;
  } exp_t;
  exp_t  sb[$];
  string nq[$];
  int    checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_ctrl #(.CNT_W(4), .HALT_ON_SYSTEM(1'b1)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel_insn(mem_sel_insn),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .retire(retire), .halted(halted),
    .state(state), .instret(instret)
  );
  // Monitor: one expected record per cycle, sampled on the falling edge
  always @(negedge clk) begin
    exp_t  e, a;
    string nm;
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      nm = nq.pop_front();
      a  = '{state, {mem_req, mem_we, mem_sel_insn, ir_we, pc_we, reg_we, retire, halted},
             pc_sel, wb_sel, {alu_a_sel, alu_b_sel}, instret};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s t=%0t: got st=%0d fl=%b pcs=%0d wbs=%0d ab=%b inst=%0d, want st=%0d fl=%b pcs=%0d wbs=%0d ab=%b inst=%0d",
                 nm, $time, a.st, a.fl, a.pcs, a.wbs, a.ab, a.inst, e.st, e.fl, e.pcs, e.wbs, e.ab, e.inst);
      end
    end
  end
  // fl bit order: mem_req mem_we mem_sel_insn ir_we pc_we reg_we retire halted
  task automatic step(input string nm, input logic r, input logic [6:0] op, input logic bt, input logic rdy,
                      input logic [2:0] st, input logic [7:0] fl, input logic [1:0] pcs, input logic [1:0] wbs,
                      input logic [1:0] ab, input logic [3:0] inst);
    run = r; opcode = op; branch_taken = bt; mem_ready = rdy;
    sb.push_back('{st, fl, pcs, wbs, ab, inst});
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  task automatic fd(input logic [6:0] op, input logic [3:0] inst);
    step("fetch", 1, op, 0, 1, 3'd1, 8'hB0, 2'd0, 2'd0, 2'b00, inst);
    step("decode", 1, op, 0, 1, 3'd2, 8'h00, 2'd0, 2'd0, 2'b00, inst);
  endtask
  initial begin
    reset = 1'b0; run = 1'b0; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    step("rst", 0, 7'h00, 0, 0, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd0);
    step("rst_run", 1, 7'h13, 1, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd0);
    reset = 1'b1;
    step("idle", 1, 7'h13, 0, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd0);
    fd(7'h13, 0);
    step("addi_exec", 1, 7'h13, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b01, 4'd0);
    step("addi_wb", 1, 7'h13, 0, 1, 3'd5, 8'h0E, 2'd0, 2'd0, 2'b01, 4'd0);
    fd(7'h03, 1);
    step("ld_exec", 1, 7'h03, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b01, 4'd1);
    for (int i = 0; i < 3; i++) step("ld_memwait", 1, 7'h03, 0, 0, 3'd4, 8'h80, 2'd0, 2'd0, 2'b01, 4'd1);
    step("ld_memrdy", 1, 7'h03, 0, 1, 3'd4, 8'h80, 2'd0, 2'd0, 2'b01, 4'd1);
    step("ld_wb", 1, 7'h03, 0, 1, 3'd5, 8'h0E, 2'd0, 2'd1, 2'b01, 4'd1);
    fd(7'h63, 2);
    step("br_taken", 1, 7'h63, 1, 1, 3'd3, 8'h0A, 2'd2, 2'd0, 2'b11, 4'd2);
    step("fetch_wait", 1, 7'h63, 1, 0, 3'd1, 8'hA0, 2'd0, 2'd0, 2'b00, 4'd3);
    fd(7'h63, 3);
    step("br_not", 1, 7'h63, 0, 1, 3'd3, 8'h0A, 2'd0, 2'd0, 2'b11, 4'd3);
    fd(7'h6F, 4);
    step("jal_exec", 1, 7'h6F, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b11, 4'd4);
    step("jal_wb", 1, 7'h6F, 0, 1, 3'd5, 8'h0E, 2'd1, 2'd2, 2'b11, 4'd4);
    fd(7'h67, 5);
    step("jalr_exec", 1, 7'h67, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b01, 4'd5);
    step("jalr_wb", 1, 7'h67, 0, 1, 3'd5, 8'h0E, 2'd1, 2'd2, 2'b01, 4'd5);
    fd(7'h17, 6);
    step("auipc_exec", 1, 7'h17, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b11, 4'd6);
    step("auipc_wb", 1, 7'h17, 0, 1, 3'd5, 8'h0E, 2'd0, 2'd0, 2'b11, 4'd6);
    fd(7'h23, 7);
    step("st_exec", 1, 7'h23, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b01, 4'd7);
    step("st_memwait", 1, 7'h23, 0, 0, 3'd4, 8'hC0, 2'd0, 2'd0, 2'b01, 4'd7);
    step("st_memrdy", 1, 7'h23, 0, 1, 3'd4, 8'hCA, 2'd0, 2'd0, 2'b01, 4'd7);
    fd(7'h0F, 8);
    step("fence_exec", 1, 7'h0F, 0, 1, 3'd3, 8'h0A, 2'd0, 2'd0, 2'b00, 4'd8);
    fd(7'h33, 9);
    step("add_exec_run0", 0, 7'h33, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b00, 4'd9);
    step("add_wb_run0", 0, 7'h33, 0, 1, 3'd5, 8'h0E, 2'd0, 2'd0, 2'b00, 4'd9);
    step("idle_run0", 0, 7'h33, 0, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd10);
    step("idle_run0", 0, 7'h33, 0, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd10);
    step("idle_run1", 1, 7'h33, 0, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd10);
    for (int i = 0; i < 6; i++) begin
      fd(7'h0F, 4'(10 + i));
      step("fence_wrap", 1, 7'h0F, 0, 1, 3'd3, 8'h0A, 2'd0, 2'd0, 2'b00, 4'(10 + i));
    end
    fd(7'h13, 0);
    step("addi_exec", 1, 7'h13, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b01, 4'd0);
    step("addi_wb", 1, 7'h13, 0, 1, 3'd5, 8'h0E, 2'd0, 2'd0, 2'b01, 4'd0);
    fd(7'h23, 1);
    step("st_exec", 1, 7'h23, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b01, 4'd1);
    step("st_memwait", 1, 7'h23, 0, 0, 3'd4, 8'hC0, 2'd0, 2'd0, 2'b01, 4'd1);
    reset = 1'b0;
    step("async_rst", 1, 7'h23, 0, 0, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd0);
    reset = 1'b1;
    step("idle", 1, 7'h13, 0, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd0);
    fd(7'h13, 0);
    step("addi_exec", 1, 7'h13, 0, 1, 3'd3, 8'h00, 2'd0, 2'd0, 2'b01, 4'd0);
    step("addi_wb", 1, 7'h13, 0, 1, 3'd5, 8'h0E, 2'd0, 2'd0, 2'b01, 4'd0);
    fd(7'h00, 1);
    for (int i = 0; i < 20; i++) step("halt_illegal", 1, 7'h00, 1, 1, 3'd6, 8'h01, 2'd0, 2'd0, 2'b00, 4'd1);
    reset = 1'b0;
    step("rst2", 1, 7'h73, 0, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd0);
    reset = 1'b1;
    step("idle", 1, 7'h73, 0, 1, 3'd0, 8'h00, 2'd0, 2'd0, 2'b00, 4'd0);
    fd(7'h73, 0);
    for (int i = 0; i < 3; i++) step("halt_system", 1, 7'h73, 0, 1, 3'd6, 8'h01, 2'd0, 2'd0, 2'b00, 4'd0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
